// File: rtl/ccd_pkg.sv
// Shared types and default sizing for the CCD correlated-double-sampling path.
//   - cds_state_t : sampler sequencing states
//   - *_DEF       : default ADC width, pixel index width and settle delay
//   - pix_word_t  : pixel word {sol, idx, data} at the default widths
package ccd_pkg;

  localparam int unsigned ADC_W_DEF      = 12;
  localparam int unsigned IDX_W_DEF      = 7;
  localparam int unsigned SETTLE_CYC_DEF = 2;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RST_SETTLE = 3'd1,
    RST_HOLD   = 3'd2,
    SIG_SETTLE = 3'd3,
    EMIT       = 3'd4
  } cds_state_t;

  typedef struct packed {
    logic                 sol;
    logic [IDX_W_DEF-1:0] idx;
    logic [ADC_W_DEF-1:0] data;
  } pix_word_t;

endpackage

// File: rtl/ccd_pix_fifo2.sv
// Generic 2-entry first-word-fall-through FIFO that drops pushes when full.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   push, push_data : write strobe and word
//   pop             : consume head word (ignored when empty)
//   head, valid     : head word (always slot 0) and not-empty flag
//   drop_c          : combinational pulse, a push was discarded because full
module ccd_pix_fifo2 #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         valid,
  output logic         drop_c
);

  logic [W-1:0] slot0_q, slot1_q;
  logic [1:0]   count_q, count_nxt;
  logic         do_pop, do_push, wr_slot1;

  // A pop frees a slot in the same cycle, so push-while-full-with-pop succeeds.
  always_comb begin
    do_pop    = pop && (count_q != 2'd0);
    do_push   = push && ((count_q != 2'd2) || do_pop);
    drop_c    = push && !do_push;
    count_nxt = count_q + 2'(do_push) - 2'(do_pop);
    wr_slot1  = (count_q - 2'(do_pop)) == 2'd1;
  end

  // Head always lives in slot 0; a pop shifts slot 1 forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
      valid   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      valid   <= (count_nxt != 2'd0);
      if (do_pop) slot0_q <= slot1_q;
      if (do_push) begin
        if (wr_slot1) slot1_q <= push_data;
        else          slot0_q <= push_data;
      end
    end
  end

  assign head = slot0_q;

endmodule

// File: rtl/ccd_cds_sampler.sv
// CCD correlated double sampler: samples the ADC at the reset and signal
// levels of each pixel, emits max(reset - signal, 0) with a line-relative
// index into a 2-entry valid/ready FIFO.
// Optional build macro CCD_CDS_AVG_EN: average two consecutive samples per
// level (SETTLE_CYC legal range becomes 1..2, otherwise 1..3).
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   phi_p, phi_l2, phi_r        : phase generator outputs
//   adc_data                    : ADC word, valid every cycle
//   clr_err                     : clears seq_err / ovf (a same-cycle set wins)
//   pix_data, pix_idx, pix_sol  : head pixel word
//   pix_valid, pix_ready        : output handshake
//   seq_err, ovf                : sticky phase-order / FIFO-overflow flags
module ccd_cds_sampler
  import ccd_pkg::*;
#(
  parameter int unsigned ADC_W      = ADC_W_DEF,
  parameter int unsigned IDX_W      = IDX_W_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             phi_p,
  input  logic             phi_l2,
  input  logic             phi_r,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             clr_err,
  output logic [ADC_W-1:0] pix_data,
  output logic [IDX_W-1:0] pix_idx,
  output logic             pix_sol,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             seq_err,
  output logic             ovf
);

  localparam int unsigned WORD_W    = 1 + IDX_W + ADC_W;
  localparam int unsigned CNT_W     = 2;
`ifdef CCD_CDS_AVG_EN
  localparam int unsigned CNT_FIRST = SETTLE_CYC - 1;
  localparam int unsigned CNT_LAST  = SETTLE_CYC;
`else
  localparam int unsigned CNT_LAST  = SETTLE_CYC - 1;
`endif

  cds_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             phi_r_q, phi_l2_q;
  logic             r_fall, r_rise, l2_fall;
  logic             cap_r, cap_s, seq_set, emit;
  logic [ADC_W-1:0] r_smp, s_smp, level_c;
  logic [ADC_W:0]   diff_c;
  logic [ADC_W-1:0] clamp_c;
  logic [IDX_W-1:0] idx;
  logic             sol_pend;
  logic [WORD_W-1:0] push_word, head_word;
  logic             drop_c;
`ifdef CCD_CDS_AVG_EN
  logic             cap_first;
  logic [ADC_W-1:0] smp0;
  logic [ADC_W:0]   sum_c;
`endif

  // Phase edges, seen the cycle after the input changes.
  assign r_fall  = phi_r_q && !phi_r;
  assign r_rise  = !phi_r_q && phi_r;
  assign l2_fall = phi_l2_q && !phi_l2;

  // Level value stored at the final sample point of a settle window.
`ifdef CCD_CDS_AVG_EN
  assign sum_c   = {1'b0, smp0} + {1'b0, adc_data};
  assign level_c = sum_c[ADC_W:1];
`else
  assign level_c = adc_data;
`endif

  // Borrow out of the (ADC_W+1)-bit subtract marks a negative result.
  assign diff_c    = {1'b0, r_smp} - {1'b0, s_smp};
  assign clamp_c   = diff_c[ADC_W] ? '0 : diff_c[ADC_W-1:0];
  assign push_word = {sol_pend, idx, clamp_c};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and sample strobes; phi_p overrides every other event.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_r     = 1'b0;
    cap_s     = 1'b0;
    seq_set   = 1'b0;
    emit      = 1'b0;
`ifdef CCD_CDS_AVG_EN
    cap_first = 1'b0;
`endif
    if (phi_p) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (r_fall) begin
            state_nxt = RST_SETTLE;
            cnt_nxt   = '0;
          end
        end
        RST_SETTLE: begin
          cnt_nxt = cnt + CNT_W'(1);
          if (l2_fall) begin
            seq_set   = 1'b1;
            state_nxt = IDLE;
          end else if (cnt == CNT_W'(CNT_LAST)) begin
            cap_r     = 1'b1;
            state_nxt = RST_HOLD;
          end
`ifdef CCD_CDS_AVG_EN
          else if (cnt == CNT_W'(CNT_FIRST)) cap_first = 1'b1;
`endif
        end
        RST_HOLD: begin
          if (r_rise) begin
            seq_set   = 1'b1;
            state_nxt = IDLE;
          end else if (l2_fall) begin
            state_nxt = SIG_SETTLE;
            cnt_nxt   = '0;
          end
        end
        SIG_SETTLE: begin
          cnt_nxt = cnt + CNT_W'(1);
          if (r_rise) begin
            seq_set   = 1'b1;
            state_nxt = IDLE;
          end else if (cnt == CNT_W'(CNT_LAST)) begin
            cap_s     = 1'b1;
            state_nxt = EMIT;
          end
`ifdef CCD_CDS_AVG_EN
          else if (cnt == CNT_W'(CNT_FIRST)) cap_first = 1'b1;
`endif
        end
        EMIT: begin
          emit = 1'b1;
          if (r_fall) begin
            state_nxt = RST_SETTLE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Edge history, samples, line position and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phi_r_q  <= 1'b0;
      phi_l2_q <= 1'b0;
      r_smp    <= '0;
      s_smp    <= '0;
      idx      <= '0;
      sol_pend <= 1'b1;
      seq_err  <= 1'b0;
      ovf      <= 1'b0;
`ifdef CCD_CDS_AVG_EN
      smp0     <= '0;
`endif
    end else begin
      phi_r_q  <= phi_r;
      phi_l2_q <= phi_l2;
`ifdef CCD_CDS_AVG_EN
      if (cap_first) smp0 <= adc_data;
`endif
      if (cap_r) r_smp <= level_c;
      if (cap_s) s_smp <= level_c;
      if (phi_p) begin
        idx      <= '0;
        sol_pend <= 1'b1;
      end else if (emit) begin
        idx      <= idx + IDX_W'(1);
        sol_pend <= 1'b0;
      end
      seq_err <= seq_set || (seq_err && !clr_err);
      ovf     <= drop_c  || (ovf && !clr_err);
    end
  end

  ccd_pix_fifo2 #(
    .W (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (emit),
    .push_data (push_word),
    .pop       (pix_valid && pix_ready),
    .head      (head_word),
    .valid     (pix_valid),
    .drop_c    (drop_c)
  );

  assign pix_sol  = head_word[WORD_W-1];
  assign pix_idx  = head_word[ADC_W +: IDX_W];
  assign pix_data = head_word[ADC_W-1:0];

endmodule

// File: tb/tb_ccd_cds_sampler.sv
// Directed bench for ccd_cds_sampler using a 16-cycle phase pattern:
// phi_r high t=0..3 (falls t=4), phi_l2 high t=0..9 (falls t=10).
module tb_ccd_cds_sampler;
  import ccd_pkg::*;

`ifdef CCD_CDS_AVG_EN
  localparam int EMIT_T  = 14;
  localparam int VALID_T = 15;
  localparam logic [11:0] DUAL_EXP = 12'h502;
`else
  localparam int EMIT_T  = 13;
  localparam int VALID_T = 14;
  localparam logic [11:0] DUAL_EXP = 12'h501;
`endif

  logic        clk, rst_n;
  logic        phi_p, phi_l2, phi_r, clr_err, pix_ready;
  logic [11:0] adc_data, pix_data;
  logic [6:0]  pix_idx;
  logic        pix_sol, pix_valid, seq_err, ovf;

  int n_vec = 0;
  int n_err = 0;
  int cur_t = -1;

  typedef struct {
    pix_word_t w;
    int        t;
  } rec_t;
  rec_t q[$];

  ccd_cds_sampler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .phi_p     (phi_p),
    .phi_l2    (phi_l2),
    .phi_r     (phi_r),
    .adc_data  (adc_data),
    .clr_err   (clr_err),
    .pix_data  (pix_data),
    .pix_idx   (pix_idx),
    .pix_sol   (pix_sol),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .seq_err   (seq_err),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted word with the pixel-relative cycle it left on.
  always @(negedge clk) begin
    if (rst_n && pix_valid && pix_ready) begin
      rec_t r;
      r.w.sol  = pix_sol;
      r.w.idx  = pix_idx;
      r.w.data = pix_data;
      r.t      = cur_t;
      q.push_back(r);
    end
  end

  // mode 0: well-formed, 1: phi_l2 falls one cycle after phi_r, 2: phi_p at t=11
  task automatic drive_pixel(input logic [11:0] r0, r1, s0, s1,
                             input int mode, input int t_lo, input int t_hi);
    for (int t = t_lo; t <= t_hi; t++) begin
      @(posedge clk); #1;
      cur_t  = t;
      phi_r  = (t < 4);
      phi_l2 = (mode == 1) ? (t < 5) : (t < 10);
      phi_p  = (mode == 2) && (t == 11);
      if (t >= 4 && t <= 6)        adc_data = r0;
      else if (t >= 7 && t <= 9)   adc_data = r1;
      else if (t >= 10 && t <= 12) adc_data = s0;
      else if (t >= 13)            adc_data = s1;
      else                         adc_data = 12'hFFF;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cur_t = -1;
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #1;
    cur_t     = -1;
    pix_ready = v;
  endtask

  task automatic line_start();
    @(posedge clk); #1;
    cur_t = -1;
    phi_p = 1'b1;
    @(posedge clk); #1;
    phi_p = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; phi_p = 1'b0; phi_r = 1'b1; phi_l2 = 1'b1;
    adc_data = 12'h000; clr_err = 1'b0; pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    settle();
    n_vec++; if (pix_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", pix_valid); end
    n_vec++; if (pix_data !== 12'h000) begin n_err++; $display("FAIL reset_data: got %h expected 000", pix_data); end
    n_vec++; if (pix_idx !== 7'd0) begin n_err++; $display("FAIL reset_idx: got %0d expected 0", pix_idx); end
    n_vec++; if (pix_sol !== 1'b0) begin n_err++; $display("FAIL reset_sol: got %b expected 0", pix_sol); end
    n_vec++; if ({seq_err, ovf} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b expected 00", {seq_err, ovf}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    q.delete();
    line_start();
    for (int p = 0; p < 3; p++) drive_pixel(12'h800, 12'h800, 12'h300, 12'h300, 0, 0, 15);
    settle();
    n_vec++; if (q.size() != 3) begin n_err++; $display("FAIL nominal_count: got %0d expected 3", q.size()); end
    for (int i = 0; i < q.size() && i < 3; i++) begin
      n_vec++; if (q[i].w.data !== 12'h500) begin n_err++; $display("FAIL nominal_data[%0d]: got %h expected 500", i, q[i].w.data); end
      n_vec++; if (q[i].w.idx !== 7'(i)) begin n_err++; $display("FAIL nominal_idx[%0d]: got %0d expected %0d", i, q[i].w.idx, i); end
      n_vec++; if (q[i].w.sol !== (i == 0)) begin n_err++; $display("FAIL nominal_sol[%0d]: got %b expected %b", i, q[i].w.sol, i == 0); end
      n_vec++; if (q[i].t != VALID_T) begin n_err++; $display("FAIL nominal_latency[%0d]: got t=%0d expected t=%0d", i, q[i].t, VALID_T); end
    end
  endtask

  // Distinct values at each candidate sample cycle exercise averaging or sample selection.
  task automatic test_dual_sample();
    q.delete();
    drive_pixel(12'h801, 12'h803, 12'h300, 12'h301, 0, 0, 15);
    settle();
    n_vec++; if (q.size() != 1) begin n_err++; $display("FAIL dual_count: got %0d expected 1", q.size()); end
    else begin
      n_vec++; if (q[0].w.data !== DUAL_EXP) begin n_err++; $display("FAIL dual_data: got %h expected %h", q[0].w.data, DUAL_EXP); end
      n_vec++; if (q[0].w.idx !== 7'd3) begin n_err++; $display("FAIL dual_idx: got %0d expected 3", q[0].w.idx); end
      n_vec++; if (q[0].t != VALID_T) begin n_err++; $display("FAIL dual_latency: got t=%0d expected t=%0d", q[0].t, VALID_T); end
    end
  endtask

  task automatic test_clamp();
    logic [11:0] rl [3] = '{12'h100, 12'h180, 12'hFFF};
    logic [11:0] sl [3] = '{12'h180, 12'h180, 12'h000};
    logic [11:0] ex [3] = '{12'h000, 12'h000, 12'hFFF};
    q.delete();
    for (int p = 0; p < 3; p++) drive_pixel(rl[p], rl[p], sl[p], sl[p], 0, 0, 15);
    settle();
    n_vec++; if (q.size() != 3) begin n_err++; $display("FAIL clamp_count: got %0d expected 3", q.size()); end
    for (int i = 0; i < q.size() && i < 3; i++) begin
      n_vec++; if (q[i].w.data !== ex[i]) begin n_err++; $display("FAIL clamp_data[%0d]: got %h expected %h", i, q[i].w.data, ex[i]); end
      n_vec++; if (q[i].w.idx !== 7'(4 + i)) begin n_err++; $display("FAIL clamp_idx[%0d]: got %0d expected %0d", i, q[i].w.idx, 4 + i); end
    end
    n_vec++; if ({seq_err, ovf} !== 2'b00) begin n_err++; $display("FAIL clamp_flags: got %b expected 00", {seq_err, ovf}); end
  endtask

  task automatic test_backpressure();
    q.delete();
    set_ready(1'b0);
    drive_pixel(12'h800, 12'h800, 12'h300, 12'h300, 0, 0, 15);
    drive_pixel(12'h800, 12'h800, 12'h310, 12'h310, 0, 0, 15);
    drive_pixel(12'h800, 12'h800, 12'h320, 12'h320, 0, 0, 15);
    settle();
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL bp_ovf_set: got %b expected 1", ovf); end
    n_vec++; if (pix_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b expected 1", pix_valid); end
    n_vec++; if (pix_idx !== 7'd7) begin n_err++; $display("FAIL bp_head_idx: got %0d expected 7", pix_idx); end
    set_ready(1'b1);
    idle_cycles(3);
    settle();
    n_vec++; if (q.size() != 2) begin n_err++; $display("FAIL bp_count: got %0d expected 2", q.size()); end
    else begin
      n_vec++; if (q[0].w.data !== 12'h500 || q[0].w.idx !== 7'd7) begin n_err++; $display("FAIL bp_word0: got %h/%0d expected 500/7", q[0].w.data, q[0].w.idx); end
      n_vec++; if (q[1].w.data !== 12'h4F0 || q[1].w.idx !== 7'd8) begin n_err++; $display("FAIL bp_word1: got %h/%0d expected 4f0/8", q[1].w.data, q[1].w.idx); end
    end
    n_vec++; if (pix_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b expected 0", pix_valid); end
    @(posedge clk); #1;
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    settle();
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL bp_ovf_clr: got %b expected 0", ovf); end
  endtask

  task automatic test_phi_p_abort();
    q.delete();
    drive_pixel(12'h800, 12'h800, 12'h300, 12'h300, 2, 0, 15);
    settle();
    n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL abort_no_output: got %0d words expected 0", q.size()); end
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL abort_seq_err: got %b expected 0", seq_err); end
    drive_pixel(12'h800, 12'h800, 12'h300, 12'h300, 0, 0, 15);
    settle();
    n_vec++; if (q.size() != 1) begin n_err++; $display("FAIL abort_next_count: got %0d expected 1", q.size()); end
    else begin
      n_vec++; if (q[0].w.idx !== 7'd0 || q[0].w.sol !== 1'b1) begin n_err++; $display("FAIL abort_next_word: got idx=%0d sol=%b expected idx=0 sol=1", q[0].w.idx, q[0].w.sol); end
    end
  endtask

  task automatic test_seq_err();
    q.delete();
    drive_pixel(12'h800, 12'h800, 12'h300, 12'h300, 1, 0, 15);
    settle();
    n_vec++; if (seq_err !== 1'b1) begin n_err++; $display("FAIL seq_err_set: got %b expected 1", seq_err); end
    n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL seq_no_output: got %0d words expected 0", q.size()); end
    drive_pixel(12'h800, 12'h800, 12'h300, 12'h300, 0, 0, 15);
    settle();
    n_vec++; if (q.size() != 1) begin n_err++; $display("FAIL seq_next_count: got %0d expected 1", q.size()); end
    else begin
      n_vec++; if (q[0].w.data !== 12'h500 || q[0].w.idx !== 7'd1 || q[0].w.sol !== 1'b0) begin
        n_err++; $display("FAIL seq_next_word: got %h/%0d/%b expected 500/1/0", q[0].w.data, q[0].w.idx, q[0].w.sol);
      end
    end
    n_vec++; if (seq_err !== 1'b1) begin n_err++; $display("FAIL seq_err_sticky: got %b expected 1", seq_err); end
  endtask

  task automatic test_async_reset();
    q.delete();
    set_ready(1'b0);
    drive_pixel(12'h800, 12'h800, 12'h300, 12'h300, 0, 0, 15);
    settle();
    n_vec++; if (pix_valid !== 1'b1 || pix_idx !== 7'd2) begin n_err++; $display("FAIL ares_pre: got valid=%b idx=%0d expected 1/2", pix_valid, pix_idx); end
    drive_pixel(12'h800, 12'h800, 12'h300, 12'h300, 0, 0, EMIT_T);
    rst_n = 1'b0;
    #1;
    n_vec++; if (pix_valid !== 1'b0) begin n_err++; $display("FAIL ares_valid: got %b expected 0", pix_valid); end
    n_vec++; if (pix_data !== 12'h000 || pix_idx !== 7'd0 || pix_sol !== 1'b0) begin
      n_err++; $display("FAIL ares_word: got %h/%0d/%b expected 000/0/0", pix_data, pix_idx, pix_sol);
    end
    n_vec++; if ({seq_err, ovf} !== 2'b00) begin n_err++; $display("FAIL ares_flags: got %b expected 00", {seq_err, ovf}); end
    @(negedge clk);
    rst_n = 1'b1;
    drive_pixel(12'h800, 12'h800, 12'h300, 12'h300, 0, EMIT_T + 1, 15);
    set_ready(1'b1);
    q.delete();
    drive_pixel(12'h800, 12'h800, 12'h300, 12'h300, 0, 0, 15);
    settle();
    n_vec++; if (q.size() != 1) begin n_err++; $display("FAIL ares_next_count: got %0d expected 1", q.size()); end
    else begin
      n_vec++; if (q[0].w.data !== 12'h500 || q[0].w.idx !== 7'd0 || q[0].w.sol !== 1'b1) begin
        n_err++; $display("FAIL ares_next_word: got %h/%0d/%b expected 500/0/1", q[0].w.data, q[0].w.idx, q[0].w.sol);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_dual_sample();
    test_clamp();
    test_backpressure();
    test_phi_p_abort();
    test_seq_err();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ccd_cds_sampler.md
Name: ccd_cds_sampler

Overview:
- Sits directly downstream of the CCD clock/phase generator and consumes its phi_p, phi_l2 and phi_r outputs.
- Samples the external ADC word twice per pixel using correlated double sampling (CDS): once at the reset level, once at the signal level.
- Emits the pixel value as reset minus signal, clamped at 0, with a line-relative pixel index.
- Output is a valid/ready stream buffered in a 2-entry FIFO, feeding the readout/packing stage.

Parameters:
- ADC_W, 12, ADC sample width in bits; also the pixel output width.
- IDX_W, 7, pixel index width; the index wraps modulo 2^IDX_W.
- SETTLE_CYC, 2, cycles from a qualifying phase edge to the sample point; legal range 1..3.

Ports:
- clk, in, 1, single system clock; all inputs are synchronous to it.
- rst_n, in, 1, asynchronous active-low reset.
- phi_p, in, 1, parallel-transfer pulse; marks a new line.
- phi_l2, in, 1, horizontal phase 2; its falling edge dumps charge onto the sense node.
- phi_r, in, 1, sense-node reset; its falling edge starts the reset-level window.
- adc_data, in, ADC_W, ADC output, valid every cycle.
- clr_err, in, 1, synchronous clear of the sticky flags.
- pix_data, out, ADC_W, CDS pixel value.
- pix_idx, out, IDX_W, pixel index within the line.
- pix_sol, out, 1, high on the first pixel after phi_p.
- pix_valid, out, 1, output word valid.
- pix_ready, in, 1, consumer accepts the word.
- seq_err, out, 1, sticky flag: phase-order violation.
- ovf, out, 1, sticky flag: pixel dropped because the FIFO was full.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, idx counter 0, sol_pend 1.
- Edge detection: one register each for phi_r and phi_l2; fall = previous 1 and current 0. Both are detected one cycle after the input edge.
- FSM states and transitions:
  - IDLE: phi_r fall -> RST_SETTLE with cnt=0.
  - RST_SETTLE: cnt increments each cycle. When cnt==SETTLE_CYC-1, capture r_smp=adc_data and go to RST_HOLD. phi_l2 fall here sets seq_err and returns to IDLE.
  - RST_HOLD: phi_l2 fall -> SIG_SETTLE with cnt=0. phi_r rise here sets seq_err and returns to IDLE.
  - SIG_SETTLE: when cnt==SETTLE_CYC-1, capture s_smp=adc_data and go to EMIT. phi_r rise here sets seq_err and returns to IDLE.
  - EMIT (1 cycle): push {diff, idx, sol_pend} into the FIFO, then idx+=1 and sol_pend=0. Then go to IDLE, or straight to RST_SETTLE if phi_r falls in that same cycle.
- Arithmetic: diff = r_smp - s_smp computed at ADC_W+1 bits signed. A negative result outputs 0; otherwise output the low ADC_W bits. No rounding.
- phi_p high (any state): abort any sequence in progress without seq_err, go to IDLE, set idx=0 and sol_pend=1. phi_p has priority over all other events in the same cycle.
- idx wraps from 2^IDX_W-1 to 0 without a flag.
- FIFO: 2 entries, first-word fall-through.
  - pix_valid = not empty.
  - Pop on pix_valid & pix_ready.
  - A push while full (with no pop in that same cycle) drops the new word and sets ovf.
  - A simultaneous push and pop while full succeeds.
- Latency: s_smp capture -> EMIT is 1 cycle; EMIT -> pix_valid is the next cycle when the FIFO was empty.
- clr_err clears seq_err and ovf. A set event in the same cycle wins.
- With the default generator timing (16-cycle pixel, phi_r high for 4 cycles), one pixel is produced per 16 cycles.

Optional Feature:
- Macro: CCD_CDS_AVG_EN.
- When defined: each level is sampled at cnt==SETTLE_CYC-1 and at cnt==SETTLE_CYC. The two samples are summed at ADC_W+1 bits and the stored value is sum>>1 (truncating). The FSM leaves RST_SETTLE and SIG_SETTLE one cycle later, and the legal SETTLE_CYC range becomes 1..2.
- When undefined: single sample per level, and no adder is synthesised.

Decomposition:
- Package ccd_pkg holds:
  - the state enum (IDLE, RST_SETTLE, RST_HOLD, SIG_SETTLE, EMIT);
  - default ADC_W, IDX_W and SETTLE_CYC constants;
  - the packed pixel-word typedef {sol, idx, data}.
- Sub-module ccd_pix_fifo2: a generic 2-entry FWFT FIFO with a full-drop output. ccd_cds_sampler instantiates it and owns the ovf sticky.

Test Plan:
- Nominal pixel: drive the 16-cycle phase pattern, adc=0x800 in the reset window and 0x300 in the signal window, pix_ready=1 -> pix_data=0x500, idx 0,1,2…, sol=1 only on the first pixel after phi_p.
- Clamp: reset level 0x100, signal level 0x180 -> pix_data=0x000 and no error flag.
- Backpressure: hold pix_ready=0 for 3 pixels -> two words retained in order, third dropped, ovf=1. Then ready=1 drains words idx0 and idx1; clr_err -> ovf=0.
- Sequence error: phi_l2 falls 1 cycle after phi_r falls with SETTLE_CYC=2 -> seq_err=1 and no pixel emitted. The next well-formed pixel is emitted normally.
- Mid-pixel phi_p in SIG_SETTLE, plus async rst_n low during EMIT -> phi_p: no output, next pixel has idx=0 and sol=1. rst_n low: all outputs 0 immediately and the FIFO is emptied.
- With CCD_CDS_AVG_EN defined: reset samples 0x801/0x803 and signal samples 0x300/0x301 -> stored levels 0x802 and 0x300, pix_data=0x502, one cycle later than in the nominal case.
